// File: rtl/fan_gear_if.sv
// Bundles the gear sequencer's inputs from the state manager, timer and battery
// monitor, and its sequenced outputs to the downstream consumers.
interface fan_gear_if;
   logic       tick_100ms;
   logic [1:0] req_state;
   logic [7:0] battery;
   logic       battery_empty;
   logic       charging;
   logic [1:0] fan_state;
   logic       ramping;
   logic       derated;

   modport master (
      output tick_100ms,
      output req_state,
      output battery,
      output battery_empty,
      output charging,
      input  fan_state,
      input  ramping,
      input  derated
   );

   modport slave (
      input  tick_100ms,
      input  req_state,
      input  battery,
      input  battery_empty,
      input  charging,
      output fan_state,
      output ramping,
      output derated
   );
endinterface

// File: rtl/fan_gear_sequencer.sv
// Turns the requested fan gear into a sequenced effective gear: soft-started
// up-shifts, one-per-tick down-shifts, low-battery capping and empty override.
module fan_gear_sequencer #(
   parameter int unsigned STEP_TICKS = 5,
   parameter logic [7:0]  LOW_BATT   = 8'd20,
   parameter logic [7:0]  HYST       = 8'd5,
   parameter logic [1:0]  CAP_GEAR   = 2'b01
) (
   input  logic       clk,
   input  logic       rst_n,
   fan_gear_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

   localparam logic [3:0] CNT_MAX   = 4'(STEP_TICKS - 1);
   localparam logic [8:0] REL_LEVEL = {1'b0, LOW_BATT} + {1'b0, HYST};

   state_t     state_reg, state_next;
   logic [1:0] fan_reg, fan_next;
   logic [3:0] cnt_reg, cnt_next;
   logic       derated_reg, derated_next;
   logic [1:0] target;

   // Set and clear conditions are disjoint, so the band between them holds.
   always_comb begin
      derated_next = derated_reg;
      if (!bus.charging && (bus.battery < LOW_BATT)) begin
         derated_next = 1'b1;
      end else if (bus.charging || ({1'b0, bus.battery} >= REL_LEVEL)) begin
         derated_next = 1'b0;
      end
   end

   always_comb begin
      target = bus.req_state;
      if (bus.battery_empty) begin
         target = 2'b00;
      end else if (derated_reg && (bus.req_state > CAP_GEAR)) begin
         target = CAP_GEAR;
      end
   end

   always_comb begin
      state_next = state_reg;
      fan_next   = fan_reg;
      cnt_next   = cnt_reg;
      if (bus.battery_empty) begin
         state_next = IDLE;
         fan_next   = 2'b00;
         cnt_next   = 4'd0;
      end else if (fan_reg == target) begin
         state_next = IDLE;
         cnt_next   = 4'd0;
      end else if (target > fan_reg) begin
         state_next = UP;
         if (state_reg != UP) begin
            cnt_next = 4'd0;
         end else if (bus.tick_100ms) begin
            if (cnt_reg == CNT_MAX) begin
               fan_next = fan_reg + 2'd1;
               cnt_next = 4'd0;
               // Landing on target this edge ends the ramp without an extra cycle.
               if (fan_next == target) begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 4'd1;
            end
         end
      end else begin
         state_next = DOWN;
         cnt_next   = 4'd0;
         if ((state_reg == DOWN) && bus.tick_100ms) begin
            fan_next = fan_reg - 2'd1;
            if (fan_next == target) begin
               state_next = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         fan_reg     <= 2'b00;
         cnt_reg     <= 4'd0;
         derated_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         fan_reg     <= fan_next;
         cnt_reg     <= cnt_next;
         derated_reg <= derated_next;
      end
   end

   assign bus.fan_state = fan_reg;
   assign bus.ramping   = (state_reg != IDLE);
   assign bus.derated   = derated_reg;

   a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_reg <= CNT_MAX);

endmodule

// File: tb/tb_fan_gear_sequencer.sv
// Directed sequences, a stimulus table and a randomized run checked against a
// gear-level reference model of the fan sequencer.
module tb_fan_gear_sequencer;
   localparam int STEP = 5;
   localparam int LOW  = 20;
   localparam int HYST = 5;
   localparam int CAP  = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fan_gear_if bus ();

   fan_gear_sequencer #(
      .STEP_TICKS (STEP),
      .LOW_BATT   (8'(LOW)),
      .HYST       (8'(HYST)),
      .CAP_GEAR   (2'(CAP))
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: gear, progress toward the next up-step, ramp direction.
   int m_fan, m_cnt, m_dir, m_der;

   function automatic void model_reset();
      m_fan = 0; m_cnt = 0; m_dir = 0; m_der = 0;
   endfunction

   function automatic void model_step();
      int tgt, want, nder;
      nder = m_der;
      if (!bus.charging && int'(bus.battery) < LOW) nder = 1;
      else if (bus.charging || int'(bus.battery) >= LOW + HYST) nder = 0;
      if (bus.battery_empty) tgt = 0;
      else if (m_der != 0 && int'(bus.req_state) > CAP) tgt = CAP;
      else tgt = int'(bus.req_state);
      if (bus.battery_empty) begin
         m_fan = 0; m_cnt = 0; m_dir = 0;
      end else if (tgt == m_fan) begin
         m_cnt = 0; m_dir = 0;
      end else begin
         want = (tgt > m_fan) ? 1 : -1;
         if (m_dir != want) begin
            m_dir = want; m_cnt = 0;
         end else if (bus.tick_100ms) begin
            if (want < 0) begin
               m_fan = m_fan - 1;
            end else begin
               m_cnt = m_cnt + 1;
               if (m_cnt == STEP) begin
                  m_fan = m_fan + 1; m_cnt = 0;
               end
            end
            if (m_fan == tgt) m_dir = 0;
         end
      end
      m_der = nder;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input int fan, input int ramp, input int der);
      chk({name, ".fan"},  int'(bus.fan_state), fan);
      chk({name, ".ramp"}, int'(bus.ramping),   ramp);
      chk({name, ".der"},  int'(bus.derated),   der);
      $display("[%0t] %s fan=%0d ramp=%0d der=%0d", $time, name,
               bus.fan_state, bus.ramping, bus.derated);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_step(); else model_reset();
      @(negedge clk);
   endtask

   task automatic pulse(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_100ms = 1'b1; cyc();
         bus.tick_100ms = 1'b0; cyc();
      end
   endtask

   typedef struct {
      logic       tick;
      logic [1:0] req;
      logic [7:0] bat;
      logic       empty;
      logic       chg;
      int         fan;
      int         ramp;
      int         der;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic t, input logic [1:0] r, input logic [7:0] b,
                               input logic e, input logic c, input int f, input int rp,
                               input int d);
      vec_t v;
      v.tick = t; v.req = r; v.bat = b; v.empty = e; v.chg = c;
      v.fan = f; v.ramp = rp; v.der = d;
      tbl.push_back(v);
   endfunction

   initial begin
      bus.tick_100ms = 1'b0;
      bus.req_state = 2'b11;
      bus.battery = 8'd80;
      bus.battery_empty = 1'b0;
      bus.charging = 1'b0;
      model_reset();

      // Reset and up-ramp 00 -> 11
      cyc(); cyc();
      chk_out("reset", 0, 0, 0);
      rst_n = 1'b1;
      cyc();
      chk_out("up_entry", 0, 1, 0);
      pulse(4);  chk_out("up_4", 0, 1, 0);
      pulse(1);  chk_out("up_5", 1, 1, 0);
      pulse(5);  chk_out("up_10", 2, 1, 0);
      pulse(4);  chk_out("up_14", 2, 1, 0);
      bus.tick_100ms = 1'b1; cyc(); bus.tick_100ms = 1'b0;
      chk_out("up_15", 3, 0, 0);

      // Down-ramp with back-to-back ticks
      bus.req_state = 2'b00; cyc();
      chk_out("dn_entry", 3, 1, 0);
      bus.tick_100ms = 1'b1;
      cyc(); chk_out("dn_1", 2, 1, 0);
      cyc(); chk_out("dn_2", 1, 1, 0);
      cyc(); chk_out("dn_3", 0, 0, 0);
      bus.tick_100ms = 1'b0;

      // Reversal before the first up-step
      bus.req_state = 2'b11; cyc();
      pulse(3); chk_out("rev_pre", 0, 1, 0);
      bus.req_state = 2'b00; cyc();
      chk_out("rev_idle", 0, 0, 0);
      bus.req_state = 2'b11; cyc();
      pulse(4); chk_out("rev_up4", 0, 1, 0);
      pulse(1); chk_out("rev_up5", 1, 1, 0);
      pulse(10); chk_out("rev_top", 3, 0, 0);

      // Derate hysteresis
      bus.battery = 8'd25; cyc();
      bus.battery = 8'd19; cyc(); chk_out("der_set", 3, 0, 1);
      cyc(); chk_out("der_dn_entry", 3, 1, 1);
      pulse(1); chk_out("der_dn1", 2, 1, 1);
      pulse(1); chk_out("der_dn2", 1, 0, 1);
      bus.battery = 8'd22; cyc(); cyc(); cyc(); chk_out("der_hold", 1, 0, 1);
      bus.battery = 8'd25; cyc(); chk_out("der_clr", 1, 0, 0);
      cyc(); chk_out("der_up_entry", 1, 1, 0);
      pulse(5); chk_out("der_up5", 2, 1, 0);
      pulse(5); chk_out("der_up10", 3, 0, 0);

      // Empty override during an up-ramp, on a tick cycle
      bus.battery = 8'd80; bus.req_state = 2'b00; cyc(); pulse(3);
      bus.req_state = 2'b11; cyc(); pulse(12);
      chk_out("emp_pre", 2, 1, 0);
      bus.battery_empty = 1'b1; bus.tick_100ms = 1'b1; cyc();
      chk_out("emp_force", 0, 0, 0);
      cyc(); chk_out("emp_hold", 0, 0, 0);
      bus.battery_empty = 1'b0; bus.tick_100ms = 1'b0; cyc();
      chk_out("emp_entry", 0, 1, 0);
      pulse(4);  chk_out("emp_up4", 0, 1, 0);
      pulse(1);  chk_out("emp_up5", 1, 1, 0);
      pulse(5);  chk_out("emp_up10", 2, 1, 0);
      pulse(5);  chk_out("emp_up15", 3, 0, 0);

      // Asynchronous reset mid-ramp while derated
      bus.req_state = 2'b00; cyc(); pulse(3);
      bus.battery = 8'd19; cyc();
      bus.req_state = 2'b11; cyc(); pulse(2);
      chk_out("ar_pre", 0, 1, 1);
      #2 rst_n = 1'b0; model_reset();
      #1 chk_out("ar_async", 0, 0, 0);
      cyc(); cyc();
      rst_n = 1'b1; cyc();
      chk_out("ar_entry", 0, 1, 1);
      pulse(4); chk_out("ar_up4", 0, 1, 1);
      pulse(1); chk_out("ar_up5", 1, 0, 1);

      // Stimulus table from a clean reset
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      add(0, 0, 25,  0, 0, 0, 0, 0);
      add(0, 0, 20,  0, 0, 0, 0, 0);
      add(0, 0, 19,  0, 0, 0, 0, 1);
      add(0, 0, 22,  0, 0, 0, 0, 1);
      add(0, 0, 24,  0, 0, 0, 0, 1);
      add(0, 0, 19,  0, 1, 0, 0, 0);
      add(0, 0, 10,  0, 0, 0, 0, 1);
      add(0, 0, 25,  0, 0, 0, 0, 0);
      add(0, 0, 0,   0, 0, 0, 0, 1);
      add(0, 0, 255, 0, 0, 0, 0, 0);
      add(0, 0, 24,  0, 0, 0, 0, 0);
      add(0, 0, 19,  0, 0, 0, 0, 1);
      add(0, 0, 24,  0, 1, 0, 0, 0);
      add(1, 1, 80,  0, 0, 0, 1, 0);
      add(1, 1, 80,  0, 0, 0, 1, 0);
      add(1, 1, 80,  0, 0, 0, 1, 0);
      add(1, 1, 80,  0, 0, 0, 1, 0);
      add(1, 1, 80,  0, 0, 0, 1, 0);
      add(1, 1, 80,  0, 0, 1, 0, 0);
      add(0, 0, 80,  0, 0, 1, 1, 0);
      add(1, 0, 80,  0, 0, 0, 0, 0);
      add(1, 3, 80,  1, 0, 0, 0, 0);
      add(0, 3, 80,  0, 0, 0, 1, 0);
      add(0, 0, 80,  0, 0, 0, 0, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         bus.tick_100ms = tbl[i].tick;
         bus.req_state = tbl[i].req;
         bus.battery = tbl[i].bat;
         bus.battery_empty = tbl[i].empty;
         bus.charging = tbl[i].chg;
         cyc();
         chk_out($sformatf("tbl%0d", i), tbl[i].fan, tbl[i].ramp, tbl[i].der);
      end

      // Randomized run against the reference model
      for (int i = 0; i < 4000; i++) begin
         int b;
         bus.tick_100ms = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 24) == 0) bus.req_state = 2'($urandom_range(0, 3));
         if (bus.battery_empty) begin
            if ($urandom_range(0, 4) == 0) bus.battery_empty = 1'b0;
         end else if ($urandom_range(0, 79) == 0) begin
            bus.battery_empty = 1'b1;
         end
         if ($urandom_range(0, 99) == 0) bus.charging = ~bus.charging;
         b = int'(bus.battery);
         if ($urandom_range(0, 199) == 0) b = $urandom_range(0, 100);
         else if ($urandom_range(0, 3) == 0) b = b + ($urandom_range(0, 1) == 0 ? -1 : 1);
         if (b < 0) b = 0;
         if (b > 100) b = 100;
         bus.battery = 8'(b);
         cyc();
         chk($sformatf("rnd%0d.fan", i),  int'(bus.fan_state), m_fan);
         chk($sformatf("rnd%0d.ramp", i), int'(bus.ramping),   (m_dir != 0) ? 1 : 0);
         chk($sformatf("rnd%0d.der", i),  int'(bus.derated),   m_der);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fan_gear_sequencer.md
# fan_gear_sequencer

Sits between the fan state manager and the consumers of the fan state: the battery manager, LED control, dot-matrix and seven-segment paths. It converts the raw requested gear into a sequenced effective gear. Up-shifts are soft-started one gear per programmable step interval and down-shifts happen one gear per tick. While the battery is low and not charging, the gear is capped with hysteresis; an empty battery forces neutral at once. The block is one FSM plus a step counter, clocked by the system 100 Hz clock and advanced by the 100 ms timer pulse.

## Interface
Parameters:
- STEP_TICKS, 5: tick pulses per up-shift gear step (500 ms at 100 ms ticks); legal range 1..15.
- LOW_BATT, 20: derate engages when battery < LOW_BATT.
- HYST, 5: derate releases when battery >= LOW_BATT+HYST.
- CAP_GEAR, 2'b01: maximum gear while derated.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_100ms  in  1  one-cycle pulse from timer block.
- req_state  in  2  requested gear from state manager (00 neutral, 01 low, 10 mid, 11 high).
- battery  in  8  battery level 0..100, unsigned.
- battery_empty  in  1  level-sensitive empty flag.
- charging  in  1  SW0 charging flag.
- fan_state  out  2  sequenced effective gear, registered.
- ramping  out  1  high while fan_state != target (FSM not IDLE).
- derated  out  1  registered low-battery cap flag.

## Operation
- Derate flag, registered:
  - set when !charging && battery < LOW_BATT;
  - clear when charging || battery >= LOW_BATT+HYST;
  - otherwise hold.
  - Comparisons are 8-bit unsigned; LOW_BATT+HYST is computed 9-bit, with no wrap.
- target, combinational:
  - battery_empty → 00;
  - else if derated → min(req_state, CAP_GEAR);
  - else → req_state.
  - target uses the registered derated value, never the next-state value.
- FSM states: IDLE, UP, DOWN. The state is recomputed every cycle.
  - battery_empty=1 → fan_state<=00, cnt<=0, state IDLE. This has priority over everything, including a tick in the same cycle.
  - fan_state==target → IDLE, cnt<=0.
  - target>fan_state → UP. On tick: if cnt==STEP_TICKS-1, fan_state+=1 and cnt<=0; else cnt+=1.
  - target<fan_state → DOWN. On each tick, fan_state-=1 and cnt<=0.
  - Entry cycle into UP or DOWN from any other state (including a direct UP↔DOWN reversal): cnt<=0, and a tick in that cycle is ignored.
- The gear moves one step at a time only; it never skips and never overshoots target.
- cnt is 4 bits wide. It never exceeds STEP_TICKS-1.
- A req_state change mid-ramp in the same direction keeps cnt. The ramp continues toward the new target.
- ramping = (state != IDLE), registered with the state.

## Timing
- Reset (rst_n=0, asynchronous): fan_state=00, ramping=0, derated=0, cnt=0, state IDLE.
  - Outputs change immediately on rst_n low, not at the next edge.
  - Release is synchronous to the next clk edge.
- Reset asserted mid-ramp aborts the ramp; the partial cnt is discarded.
- Up-shift latency:
  - the cycle after the mismatch appears is the UP entry (cnt=0);
  - each gear step needs STEP_TICKS further ticks;
  - 00→11 with STEP_TICKS=5 takes 15 ticks after entry.
- Down-shift: one gear per tick after the entry cycle. 11→00 takes 3 ticks.
- battery_empty rising → fan_state=00 on the next clk edge. ramping=0 on that same edge.
- The derated change is visible one cycle after battery crosses its threshold. target follows in the same cycle; fan_state follows via the DOWN sequencing.
- tick_100ms asserted for multiple consecutive cycles is counted once per cycle. There is no edge detection.

## Test plan
- Reset and simple ramp:
  - Stimulus: rst_n low with req=11 held, then release, battery=80, charging=0.
  - Required: fan_state 00 during reset; then 01, 10, 11 after 5, 10, 15 ticks; ramping drops in the cycle fan_state reaches 11.
- Down-ramp:
  - Stimulus: from fan_state=11, req→00.
  - Required: one entry cycle, then 10, 01, 00 on three consecutive ticks; ramping=0 after that.
- Reversal mid-ramp:
  - Stimulus: req 00→11; after 3 ticks (fan_state=00, cnt=3) req→00.
  - Required: no up-step ever occurs; cnt cleared; ramping clears after one cycle.
- Derate hysteresis:
  - Stimulus: fan_state=11, battery steps 25→19.
  - Required: derated=1 next cycle, fan_state steps down to 01.
  - Stimulus continued: battery→22, then charging=0 held.
  - Required: derated stays 1.
  - Stimulus continued: battery=25.
  - Required: derated=0, then fan_state ramps back to 11 at 5 ticks per gear.
- Empty override:
  - Stimulus: fan_state=10 mid-up-ramp; battery_empty=1 in the same cycle as a tick.
  - Required: fan_state=00 next edge, cnt=0, ramping=0.
  - Stimulus continued: empty clears with req=11.
  - Required: a full 15-tick ramp.
- Async reset mid-ramp:
  - Stimulus: rst_n pulsed low between clock edges while in UP with cnt=2.
  - Required: outputs 00/0/0 before the next edge; cnt restarts from 0 after release.
